// File: rtl/cpu_hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard and the decode/forward logic around it.
package cpu_hazard_scoreboard_pkg;

    localparam int SB_NUM_REGS = 32;
    localparam int SB_IDX_W    = 5;

    typedef logic [SB_IDX_W-1:0] reg_idx_t;

    // bit0 = rs1, bit1 = rs2, bit2 = rs3
    typedef logic [2:0] src_mask_t;

endpackage

// File: rtl/cpu_hazard_scoreboard_entry.sv
// One per-register outstanding-write counter: saturating increment on issue,
// non-wrapping decrement on retire, synchronous clear on flush.
module cpu_hazard_scoreboard_entry #(
    parameter int COUNT_WIDTH = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_flush,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nonzero,
    output logic o_full,
    output logic o_underflow_evt
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    assign o_nonzero       = (count_q != '0);
    assign o_full          = (count_q == '1);
    // Simultaneous issue and retire cancel out, so only a lone retire can underflow.
    assign o_underflow_evt = i_dec && !i_inc && !o_nonzero;

    always_comb begin
        count_d = count_q;
        if (i_flush) begin
            count_d = '0;
        end else if (i_inc && !i_dec && !o_full) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (i_dec && !i_inc && o_nonzero) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_hazard_scoreboard.sv
// Load-use hazard scoreboard: counts in-flight late register writes and stalls decode.
// Define CPU_SCOREBOARD_RS3_EN to let the third source operand participate in o_stall.
module cpu_hazard_scoreboard
    import cpu_hazard_scoreboard_pkg::*;
#(
    parameter int COUNT_WIDTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    output logic        o_issue_full,
    input  logic        i_retire_valid,
    input  logic [4:0]  i_retire_rd,
    input  logic [2:0]  i_have_rs,
    input  logic [4:0]  i_inst_rs1,
    input  logic [4:0]  i_inst_rs2,
    input  logic [4:0]  i_inst_rs3,
    output logic        o_stall,
    output logic        o_underflow,
    output logic [31:0] o_pending
);

    logic [SB_NUM_REGS-1:0] pend_vec;
    logic [SB_NUM_REGS-1:0] full_vec;
    logic [SB_NUM_REGS-1:0] evt_vec;
    logic                   underflow_q;
    logic                   underflow_d;

    // x0 is never written, so it never holds a reservation.
    assign pend_vec[0] = 1'b0;
    assign full_vec[0] = 1'b0;
    assign evt_vec[0]  = 1'b0;

    for (genvar r = 1; r < SB_NUM_REGS; r++) begin : g_entry
        cpu_hazard_scoreboard_entry #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_entry (
            .i_clock         (i_clock),
            .i_reset         (i_reset),
            .i_flush         (i_flush),
            .i_inc           (i_issue_valid  && (i_issue_rd  == reg_idx_t'(r))),
            .i_dec           (i_retire_valid && (i_retire_rd == reg_idx_t'(r))),
            .o_nonzero       (pend_vec[r]),
            .o_full          (full_vec[r]),
            .o_underflow_evt (evt_vec[r])
        );
    end

    function automatic logic src_hit(input logic used, input reg_idx_t rs,
                                     input logic [SB_NUM_REGS-1:0] pend);
        return used && pend[rs];
    endfunction

`ifdef CPU_SCOREBOARD_RS3_EN
    assign o_stall = src_hit(i_have_rs[0], i_inst_rs1, pend_vec)
                   | src_hit(i_have_rs[1], i_inst_rs2, pend_vec)
                   | src_hit(i_have_rs[2], i_inst_rs3, pend_vec);
`else
    logic unused_rs3;
    assign unused_rs3 = ^{i_inst_rs3, i_have_rs[2]};
    assign o_stall = src_hit(i_have_rs[0], i_inst_rs1, pend_vec)
                   | src_hit(i_have_rs[1], i_inst_rs2, pend_vec);
`endif

    assign o_issue_full = full_vec[i_issue_rd];
    assign o_pending    = pend_vec;

    // Sticky until reset; flush deliberately leaves it alone.
    assign underflow_d = underflow_q | (|evt_vec);
    assign o_underflow = underflow_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed self-checking bench for cpu_hazard_scoreboard (COUNT_WIDTH = 2).
module tb_cpu_hazard_scoreboard;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_issue_valid = 1'b0;
    logic [4:0]  i_issue_rd = '0;
    logic        o_issue_full;
    logic        i_retire_valid = 1'b0;
    logic [4:0]  i_retire_rd = '0;
    logic [2:0]  i_have_rs = '0;
    logic [4:0]  i_inst_rs1 = '0;
    logic [4:0]  i_inst_rs2 = '0;
    logic [4:0]  i_inst_rs3 = '0;
    logic        o_stall;
    logic        o_underflow;
    logic [31:0] o_pending;

    int checks = 0;
    int errors = 0;

    cpu_hazard_scoreboard #(.COUNT_WIDTH(2)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_flush        (i_flush),
        .i_issue_valid  (i_issue_valid),
        .i_issue_rd     (i_issue_rd),
        .o_issue_full   (o_issue_full),
        .i_retire_valid (i_retire_valid),
        .i_retire_rd    (i_retire_rd),
        .i_have_rs      (i_have_rs),
        .i_inst_rs1     (i_inst_rs1),
        .i_inst_rs2     (i_inst_rs2),
        .i_inst_rs3     (i_inst_rs3),
        .o_stall        (o_stall),
        .o_underflow    (o_underflow),
        .o_pending      (o_pending)
    );

    always #5 i_clock = ~i_clock;

    // Advance to just after the next rising edge, then clear one-shot controls.
    task automatic tick();
        @(posedge i_clock);
        #1;
        i_issue_valid  = 1'b0;
        i_retire_valid = 1'b0;
        i_flush        = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        i_issue_valid = 1'b1;
        i_issue_rd    = rd;
        tick();
    endtask

    task automatic retire(input logic [4:0] rd);
        i_retire_valid = 1'b1;
        i_retire_rd    = rd;
        tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_have_rs = 3'b111; i_inst_rs1 = 5'd1; i_inst_rs2 = 5'd2; i_inst_rs3 = 5'd3;
        i_issue_rd = 5'd1;
        #3;
        checks++;
        if ({o_stall, o_issue_full, o_underflow, o_pending} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b full=%b uf=%b pend=%h want all 0",
                     o_stall, o_issue_full, o_underflow, o_pending);
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        i_have_rs = 3'b000;
        tick();
        checks++;
        if (o_pending !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_pend got %h want 0", o_pending);
        end
    endtask

    task automatic test_load_use();
        i_inst_rs1 = 5'd5; i_have_rs = 3'b001;
        i_issue_valid = 1'b1; i_issue_rd = 5'd5;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall_N got %b want 0", o_stall);
        end
        tick();
        checks++;
        if (o_stall !== 1'b1 || o_pending !== 32'h0000_0020) begin
            errors++;
            $display("FAIL lu_stall_N1 got stall=%b pend=%h want 1 00000020", o_stall, o_pending);
        end
        tick();
        i_retire_valid = 1'b1; i_retire_rd = 5'd5;
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall_N2 got %b want 1", o_stall);
        end
        tick();
        checks++;
        if (o_stall !== 1'b0 || o_pending !== 32'h0) begin
            errors++;
            $display("FAIL lu_stall_N3 got stall=%b pend=%h want 0 0", o_stall, o_pending);
        end
        i_have_rs = 3'b000;
    endtask

    task automatic test_saturate();
        issue(5'd7); issue(5'd7);
        i_issue_rd = 5'd7;
        checks++;
        if (o_issue_full !== 1'b0) begin
            errors++;
            $display("FAIL sat_full_at2 got %b want 0", o_issue_full);
        end
        issue(5'd7);
        i_issue_rd = 5'd7;
        checks++;
        if (o_issue_full !== 1'b1) begin
            errors++;
            $display("FAIL sat_full_at3 got %b want 1", o_issue_full);
        end
        i_issue_rd = 5'd0;
        #1;
        checks++;
        if (o_issue_full !== 1'b0) begin
            errors++;
            $display("FAIL sat_full_x0 got %b want 0", o_issue_full);
        end
        issue(5'd7);
        retire(5'd7); retire(5'd7);
        checks++;
        if (o_pending[7] !== 1'b1 || o_underflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold got pend7=%b uf=%b want 1 0", o_pending[7], o_underflow);
        end
        retire(5'd7);
        checks++;
        if (o_pending !== 32'h0 || o_underflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_drain got pend=%h uf=%b want 0 0", o_pending, o_underflow);
        end
    endtask

    task automatic test_same_cycle();
        issue(5'd9);
        i_inst_rs2 = 5'd9; i_have_rs = 3'b010;
        i_issue_valid = 1'b1; i_issue_rd = 5'd9;
        i_retire_valid = 1'b1; i_retire_rd = 5'd9;
        tick();
        checks++;
        if (o_stall !== 1'b1 || o_pending !== 32'h0000_0200) begin
            errors++;
            $display("FAIL same_cycle got stall=%b pend=%h want 1 00000200", o_stall, o_pending);
        end
        retire(5'd9);
        checks++;
        if (o_stall !== 1'b0 || o_underflow !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_drain got stall=%b uf=%b want 0 0", o_stall, o_underflow);
        end
        i_have_rs = 3'b000;
    endtask

    task automatic test_x0_and_rs3();
        issue(5'd0);
        i_inst_rs1 = 5'd0; i_have_rs = 3'b001;
        #1;
        checks++;
        if (o_pending !== 32'h0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_ignored got pend=%h stall=%b want 0 0", o_pending, o_stall);
        end
        issue(5'd12);
        i_inst_rs1 = 5'd0; i_inst_rs2 = 5'd0; i_inst_rs3 = 5'd12; i_have_rs = 3'b100;
        #1;
        checks++;
`ifdef CPU_SCOREBOARD_RS3_EN
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL rs3_stall got %b want 1", o_stall);
        end
`else
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL rs3_stall got %b want 0", o_stall);
        end
`endif
        i_inst_rs3 = 5'd0; i_inst_rs1 = 5'd12; i_have_rs = 3'b110;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL rs1_unused got %b want 0", o_stall);
        end
        i_have_rs = 3'b001;
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL rs1_used got %b want 1", o_stall);
        end
        retire(5'd12);
        i_have_rs = 3'b000;
    endtask

    task automatic test_underflow();
        retire(5'd4);
        checks++;
        if (o_underflow !== 1'b1 || o_pending !== 32'h0) begin
            errors++;
            $display("FAIL underflow_set got uf=%b pend=%h want 1 0", o_underflow, o_pending);
        end
        i_flush = 1'b1;
        tick();
        checks++;
        if (o_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky got %b want 1", o_underflow);
        end
    endtask

    task automatic test_flush();
        issue(5'd3); issue(5'd8);
        checks++;
        if (o_pending !== 32'h0000_0108) begin
            errors++;
            $display("FAIL flush_pre got %h want 00000108", o_pending);
        end
        i_flush = 1'b1; i_issue_valid = 1'b1; i_issue_rd = 5'd10;
        tick();
        i_inst_rs1 = 5'd10; i_have_rs = 3'b001;
        #1;
        checks++;
        if (o_pending !== 32'h0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got pend=%h stall=%b want 0 0", o_pending, o_stall);
        end
        i_have_rs = 3'b000;
    endtask

    task automatic test_async_reset();
        issue(5'd6); issue(5'd6); issue(5'd6);
        i_issue_rd = 5'd6; i_inst_rs1 = 5'd6; i_have_rs = 3'b001;
        #1;
        checks++;
        if (o_stall !== 1'b1 || o_issue_full !== 1'b1 || o_underflow !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got stall=%b full=%b uf=%b want 1 1 1",
                     o_stall, o_issue_full, o_underflow);
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_stall, o_issue_full, o_underflow, o_pending} !== 35'd0) begin
            errors++;
            $display("FAIL areset_now got stall=%b full=%b uf=%b pend=%h want all 0",
                     o_stall, o_issue_full, o_underflow, o_pending);
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        tick();
        checks++;
        if (o_pending !== 32'h0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL areset_after got pend=%h stall=%b want 0 0", o_pending, o_stall);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_saturate();
        test_same_cycle();
        test_x0_and_rs3();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
